seg7_reader: RTL and testbench

//  Receive-side counterpart of the hex counter/seven-segment driver: samples a 7-bit segment bus
//  (e.g. looped back on uio_in), filters glitches, decodes the stable pattern back to a 4-bit digit,
//  and checks that successive digits follow the +1 mod 16 count. Measures cycles between digit steps.

---
 rtl/seg7_pkg.sv | 61 ++++++
 rtl/seg7_stable_filter.sv | 61 ++++++
 rtl/seg7_reader.sv | 132 +++++++++++++
 tb/tb_seg7_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment reader: segment patterns,
// pattern-to-digit decode and the tracking FSM state encoding.
package seg7_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // IDLE: no reference digit yet; TRACK: last accepted digit is a valid reference.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] digit;
  } decode_t;

  // Map a segment pattern to its hex digit; legal=0 for anything not in the table.
  function automatic decode_t seg7_decode(input logic [6:0] pat);
    decode_t d;
    d.legal = 1'b1;
    d.digit = 4'h0;
    case (pat)
      SEG_0:   d.digit = 4'h0;
      SEG_1:   d.digit = 4'h1;
      SEG_2:   d.digit = 4'h2;
      SEG_3:   d.digit = 4'h3;
      SEG_4:   d.digit = 4'h4;
      SEG_5:   d.digit = 4'h5;
      SEG_6:   d.digit = 4'h6;
      SEG_7:   d.digit = 4'h7;
      SEG_8:   d.digit = 4'h8;
      SEG_9:   d.digit = 4'h9;
      SEG_A:   d.digit = 4'hA;
      SEG_B:   d.digit = 4'hB;
      SEG_C:   d.digit = 4'hC;
      SEG_D:   d.digit = 4'hD;
      SEG_E:   d.digit = 4'hE;
      SEG_F:   d.digit = 4'hF;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Synchronizes the asynchronous segment bus, counts how many consecutive
// identical samples have been seen and flags a newly stable pattern once.
module seg7_stable_filter #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_seg,
  output logic       o_accept,
  output logic [6:0] o_pattern
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  logic [6:0] r_sync1;
  logic [6:0] r_sync2;
  logic [6:0] r_prev;
  logic [6:0] r_last;
  logic [7:0] r_cnt;

  // Two-flop synchronizer for the asynchronous segment bus.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 7'h00;
      r_sync2 <= 7'h00;
    end else begin
      r_sync1 <= i_seg;
      r_sync2 <= r_sync1;
    end
  end

  // r_cnt is the number of consecutive samples equal to r_prev; restarts on a change, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 7'h00;
      r_cnt  <= 8'd0;
    end else begin
      r_prev <= r_sync2;
      if (r_sync2 != r_prev) begin
        r_cnt <= 8'd1;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // A stable pattern that differs from the last accepted one is accepted exactly once.
  assign o_accept  = (r_cnt == CNT_MAX) && (r_prev != r_last);
  assign o_pattern = r_prev;

  // Remember the last accepted pattern so a held pattern never re-fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 7'h00;
    end else if (o_accept) begin
      r_last <= r_prev;
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Seven-segment receive monitor: decodes stable patterns to digits, checks
// the +1 mod 16 count sequence and measures strobe-to-strobe period.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  input  logic                clr_err,
  output logic [3:0]          digit_out,
  output logic                digit_valid,
  output logic                digit_strobe,
  output logic                illegal,
  output logic                seq_err,
  output logic [PERIOD_W-1:0] period
);

  logic                w_accept;
  logic [6:0]          w_pattern;
  decode_t             w_dec;
  state_t              r_state;
  state_t              w_state_next;
  logic                w_set_err;
  logic                w_capture;
  logic [3:0]          w_expect;
  logic [PERIOD_W-1:0] w_period_inc;

  logic [3:0]          r_digit;
  logic                r_valid;
  logic                r_strobe;
  logic                r_illegal;
  logic                r_err;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_pcnt;

  seg7_stable_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_seg     (seg_in),
    .o_accept  (w_accept),
    .o_pattern (w_pattern)
  );

  assign w_dec        = seg7_decode(w_pattern);
  assign w_expect     = r_digit + 4'd1;
  assign w_period_inc = (r_pcnt == '1) ? '1 : r_pcnt + PERIOD_W'(1);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, sequence-error detection and period capture decisions.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_next = r_state;
    w_set_err    = 1'b0;
    w_capture    = 1'b0;
    if (w_accept) begin
      if (!w_dec.legal) begin
        w_state_next = ST_IDLE;
      end else begin
        w_state_next = ST_TRACK;
        if (r_state == ST_TRACK) begin
          w_capture = 1'b1;
          if (w_dec.digit != w_expect) begin
            w_set_err = 1'b1;
          end
        end
      end
    end
  end

  // Registered outputs: digit, validity, pulses, sticky error (set beats clear), period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit   <= 4'h0;
      r_valid   <= 1'b0;
      r_strobe  <= 1'b0;
      r_illegal <= 1'b0;
      r_err     <= 1'b0;
      r_period  <= '0;
    end else begin
      r_strobe  <= w_accept;
      r_illegal <= w_accept && !w_dec.legal;
      if (w_accept) begin
        if (w_dec.legal) begin
          r_digit <= w_dec.digit;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
      if (w_capture) begin
        r_period <= w_period_inc;
      end
    end
  end

  // Cycles since the last strobe; saturates so a stalled display reports all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (w_accept) begin
      r_pcnt <= '0;
    end else if (r_pcnt != '1) begin
      r_pcnt <= r_pcnt + PERIOD_W'(1);
    end
  end

  assign digit_out    = r_digit;
  assign digit_valid  = r_valid;
  assign digit_strobe = r_strobe;
  assign illegal      = r_illegal;
  assign seq_err      = r_err;
  assign period       = r_period;

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: directed scenarios followed by random
// pattern/hold sequences, compared every cycle against a behavioural model.
module tb_seg7_reader;

  localparam int S  = 4;
  localparam int PW = 24;

  localparam logic [6:0] TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic          clk;
  logic          rst_n;
  logic [6:0]    seg_in;
  logic          clr_err;
  logic [3:0]    digit_out;
  logic          digit_valid;
  logic          digit_strobe;
  logic          illegal;
  logic          seq_err;
  logic [PW-1:0] period;

  seg7_reader #(
    .STABLE_CYCLES (S),
    .PERIOD_W      (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .clr_err      (clr_err),
    .digit_out    (digit_out),
    .digit_valid  (digit_valid),
    .digit_strobe (digit_strobe),
    .illegal      (illegal),
    .seq_err      (seq_err),
    .period       (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int         cyc;
    logic [6:0] pat;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         clr_cyc = -1;
  int         tests = 0;
  int         fails = 0;
  logic [6:0] m_last_pat;
  int         m_digit;
  bit         m_valid, m_err, m_track, m_strobe, m_illegal;
  int         m_period;
  int         m_last_strobe;
  int         drv_digit;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (TAB[i] == p) return i;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    check("strobe",  32'(digit_strobe), 32'(m_strobe));
    check("illegal", 32'(illegal),      32'(m_illegal));
    check("digit",   32'(digit_out),    32'(m_digit));
    check("valid",   32'(digit_valid),  32'(m_valid));
    check("seq_err", 32'(seq_err),      32'(m_err));
    check("period",  32'(period),       32'(m_period));
  endtask

  // One clock: apply clr_err, advance the model for this edge, compare on the falling edge.
  task automatic tick();
    bit   clr_now;
    bit   set_now;
    int   idx;
    ev_t  ev;
    clr_err = (cyc + 1 == clr_cyc);
    clr_now = clr_err;
    @(posedge clk);
    cyc++;
    m_strobe  = 0;
    m_illegal = 0;
    set_now   = 0;
    if (evq.size() > 0 && evq[0].cyc == cyc) begin
      ev = evq.pop_front();
      m_strobe = 1;
      idx = lookup(ev.pat);
      if (idx < 0) begin
        m_illegal = 1;
        m_valid   = 0;
        m_track   = 0;
      end else begin
        if (m_track) begin
          if (idx != (m_digit + 1) % 16) begin
            m_err   = 1;
            set_now = 1;
          end
          m_period = cyc - m_last_strobe;
        end
        m_digit = idx;
        m_valid = 1;
        m_track = 1;
      end
      m_last_strobe = cyc;
    end
    if (clr_now && !set_now) m_err = 0;
    @(negedge clk);
    check_all();
  endtask

  // Present pattern p for h clock edges; a pattern held at least S samples
  // that differs from the last accepted one strobes 2+S cycles after its first edge.
  task automatic drive(input logic [6:0] p, input int h);
    ev_t e;
    if (h >= S && p != m_last_pat) begin
      e.cyc = cyc + 3 + S;
      e.pat = p;
      evq.push_back(e);
      m_last_pat = p;
    end
    seg_in = p;
    repeat (h) tick();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    seg_in  = 7'h00;
    clr_err = 1'b0;
    clr_cyc = -1;
    #1;
    check("rst_digit",   32'(digit_out),    32'd0);
    check("rst_valid",   32'(digit_valid),  32'd0);
    check("rst_strobe",  32'(digit_strobe), 32'd0);
    check("rst_illegal", 32'(illegal),      32'd0);
    check("rst_seq_err", 32'(seq_err),      32'd0);
    check("rst_period",  32'(period),       32'd0);
    evq.delete();
    m_last_pat = 7'h00; m_digit = 0; m_valid = 0; m_err = 0; m_track = 0;
    m_strobe = 0; m_illegal = 0; m_period = 0; m_last_strobe = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] p;
    int         h;
    int         r;
    rst_n   = 1'b1;
    seg_in  = 7'h00;
    clr_err = 1'b0;
    #2;
    do_reset();

    // All-dark bus after reset must never strobe.
    repeat (10) tick();

    // Digit 0 after reset, then 1 exactly 100 cycles later.
    drive(7'h3F, 100);
    check("s1_digit", 32'(digit_out), 32'd0);
    check("s1_valid", 32'(digit_valid), 32'd1);
    drive(7'h06, 30);
    check("s2_digit",  32'(digit_out), 32'd1);
    check("s2_period", 32'(period),    32'd100);
    check("s2_err",    32'(seq_err),   32'd0);

    // Three-sample glitch, then return to the already accepted pattern.
    drive(7'h5B, 3);
    drive(7'h06, 20);
    check("s3_digit", 32'(digit_out), 32'd1);

    // E, F, 0 with wrap-around from a fresh reset.
    do_reset();
    drive(7'h79, 20);
    drive(7'h71, 20);
    drive(7'h3F, 20);
    check("s4_digit",  32'(digit_out), 32'd0);
    check("s4_err",    32'(seq_err),   32'd0);
    check("s4_period", 32'(period),    32'd20);

    // Skip 0 -> 3 sets the sticky error; clear it; then clear collides with a new error.
    drive(7'h4F, 20);
    check("s5_err_set", 32'(seq_err), 32'd1);
    clr_cyc = cyc + 2;
    repeat (4) tick();
    check("s5_err_clr", 32'(seq_err), 32'd0);
    clr_cyc = cyc + 3 + S;
    drive(7'h7F, 20);
    check("s5_set_wins", 32'(seq_err), 32'd1);

    // Illegal pattern drops validity; the next legal digit restarts tracking.
    clr_cyc = cyc + 1;
    drive(7'h7E, 10);
    check("s6_valid_low", 32'(digit_valid), 32'd0);
    drive(7'h6D, 20);
    check("s6_digit", 32'(digit_out),   32'd5);
    check("s6_valid", 32'(digit_valid), 32'd1);
    check("s6_err",   32'(seq_err),     32'd0);

    // Reset in the middle of a hold.
    drive(7'h66, 3);
    do_reset();

    // Random patterns and hold lengths, including glitches and illegal codes.
    drv_digit = 0;
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      p = TAB[(drv_digit + 1) % 16];
      else if (r < 75) p = TAB[$urandom_range(0, 15)];
      else             p = 7'($urandom_range(0, 127));
      if (p == seg_in) p = p ^ 7'h01;
      if (lookup(p) >= 0) drv_digit = lookup(p);
      if ($urandom_range(0, 3) == 0) h = $urandom_range(1, S - 1);
      else                           h = $urandom_range(S, 25);
      if ($urandom_range(0, 9) == 0) clr_cyc = cyc + $urandom_range(1, 12);
      drive(p, h);
      if ($urandom_range(0, 39) == 0) do_reset();
    end
    repeat (12) tick();
    check("queue_drained", 32'(evq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
